hazard_ctrl: RTL

Pipeline hazard controller for the five-stage ARM datapath. It sequences the conditional-execution stage and the register file by generating stall, flush and forwarding controls each cycle. It also manages a wait-state handshake with a variable-latency data memory in the M stage. It sits beside the pipeline registers and consumes the E-stage branch/PC-write results produced by the condition logic.

---
 rtl/hazard_ctrl_pkg.sv | 36 +++
 rtl/mem_wait_fsm.sv | 79 +++++++
 rtl/hazard_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forwarding select encoding, memory wait-state FSM states and the PC register index.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam logic [3:0] PC_REG = 4'd15;

  // R15 reads the PC, never a forwarded result; M has priority over W.
  function automatic fwd_sel_t fwd_sel(input logic [3:0] ra,
                                       input logic       reg_write_m,
                                       input logic [3:0] wa_m,
                                       input logic       reg_write_w,
                                       input logic [3:0] wa_w);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (ra != PC_REG) begin
      if (reg_write_m && (ra == wa_m)) begin
        sel = FWD_M;
      end else if (reg_write_w && (ra == wa_w)) begin
        sel = FWD_W;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Wait-state handshake with the variable-latency data memory in the M stage.
// Holds the IDLE/WAIT FSM, the timeout counter and the sticky timeout error.
module mem_wait_fsm
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic MemReqM,
  input  logic MemAckM,
  output logic MemStall,
  output logic MemBusy,
  output logic MemErr
);

  localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TimeoutVal = TW'(MEM_TIMEOUT);

  mem_state_t    state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          timeout;

  assign timeout = (cnt_q == TimeoutVal);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (MemReqM && !MemAckM) begin
          state_d = WAIT;
          cnt_d   = TW'(1);
        end
      end
      WAIT: begin
        // Ack beats timeout when both land in the same cycle.
        if (MemAckM) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (timeout) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Release is combinational: stalls drop in the ack or timeout cycle itself.
  always_comb begin
    MemStall = 1'b0;
    unique case (state_q)
      IDLE:    MemStall = MemReqM && !MemAckM;
      WAIT:    MemStall = !MemAckM && !timeout;
      default: MemStall = 1'b0;
    endcase
    MemBusy = (state_q == WAIT);
    MemErr  = err_q;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, stall/flush controls and a
// saturating stall-cycle counter, with the M-stage memory wait-state FSM beside it.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemAckM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemBusy,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount
);

  logic             mem_stall, mem_busy;
  logic             ldr_stall, pc_wr_pending;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  mem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_fsm (
    .clk     (clk),
    .reset   (reset),
    .MemReqM (MemReqM),
    .MemAckM (MemAckM),
    .MemStall(mem_stall),
    .MemBusy (mem_busy),
    .MemErr  (MemErr)
  );

  assign ldr_stall     = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
  assign pc_wr_pending = PCSrcD || PCSrcE || PCSrcM;

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushW    = 1'b1;
    MemBusy   = 1'b0;
    if (reset) begin
      ForwardAE = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
      ForwardBE = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
      MemBusy   = mem_busy;
      if (mem_stall) begin
        // Freeze the whole pipe; a branch held in E flushes once the stall lifts.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b1;
      end else begin
        StallF = ldr_stall || pc_wr_pending;
        StallD = ldr_stall;
        FlushD = pc_wr_pending || PCSrcW || BranchTakenE;
        FlushE = ldr_stall || BranchTakenE;
        FlushW = 1'b0;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallF && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;

endmodule
